dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the core's load/store request/response interface.
- Accepts one BYTE/HWORD/WORD access per transaction, services it after a programmable wait-state count, and returns read data (sign/zero-extended) or a write acknowledge.
- Sits between the core's load/store unit and on-chip data RAM, and serves as the bench memory model for core simulation.

Parameters:
- XLEN, 32: data/address width (register size).
- DEPTH_WORDS, 1024: RAM depth in XLEN-bit words; power of two.
- WAIT_CYCLES, 2: wait states between request acceptance and response; range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  XLEN  byte address.
- req_size  in  2  2'b00 BYTE, 2'b01 HWORD, 2'b10 WORD, 2'b11 illegal.
- req_unsigned  in  1  load zero-extends (LBU/LHU); ignored for stores.
- req_wdata  in  XLEN  store data, right-aligned (bits [7:0] for SB, [15:0] for SH).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  XLEN  load result; 0 for stores and for errors.
- rsp_err  out  1  access error (see Optional Feature).

Behaviour:
- Reset (clk edge with rst=1):
  - FSM to IDLE, wait counter to 0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - RAM contents are not cleared.
  - Reset mid-transaction abandons it; a pending store that has not yet committed is dropped.
- FSM states:
  - IDLE: req_ready=1.
    - On req_valid & req_ready, capture we/addr/size/unsigned/wdata and evaluate the error.
    - WAIT_CYCLES=0: go to RESP.
    - Otherwise: load the counter with WAIT_CYCLES-1 and go to WAIT.
  - WAIT: req_ready=0. Decrement the counter; at 0, go to RESP.
  - RESP: req_ready=0, rsp_valid=1, rsp_rdata and rsp_err held stable. On rsp_ready, go to IDLE.
  - Back-to-back requests therefore occur at most once every WAIT_CYCLES+2 cycles.
- Latency: acceptance edge to first cycle of rsp_valid is WAIT_CYCLES+1 cycles.
- RAM access happens on the edge that enters RESP.
  - Word index = addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0].
  - Store:
    - BYTE writes lane addr[1:0] with wdata[7:0].
    - HWORD writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
    - WORD writes all lanes.
    - Other lanes are unchanged.
  - Load:
    - Select the byte/half at the lane, then sign-extend from bit 7/15.
    - If req_unsigned=1, zero-extend instead.
    - WORD loads are returned unchanged.
- Error conditions:
  - req_size=2'b11.
  - HWORD with addr[0]=1.
  - WORD with addr[1:0]!=0.
  - Address beyond DEPTH_WORDS*4 bytes, i.e. any upper address bit set.
- On error: no RAM write, rsp_rdata=0, and the timing is the same as a legal access.
- req_valid while req_ready=0 is ignored; the requester must hold the request.
- rsp_rdata is 0 on store responses.

Optional Feature:
- Macro: DMEM_ERR_RESP_EN.
- Defined:
  - Error conditions assert rsp_err=1 with the response.
  - The access is suppressed: no write, rdata 0.
- Undefined:
  - rsp_err is tied to 0.
  - Misaligned addresses are force-aligned: HWORD clears addr[0], WORD clears addr[1:0].
  - Out-of-range addresses wrap modulo the RAM size.
  - size 2'b11 is treated as WORD.
  - All accesses complete normally.

Test Plan:
- Reset: hold rst 2 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Word store/load: SW 0xDEADBEEF to 0x10, then LW 0x10 with WAIT_CYCLES=2 -> rsp_valid appears 3 cycles after each acceptance; load returns 0xDEADBEEF.
- Sub-word extension: after the test above, LB 0x11 -> 0xFFFFFFBE; LBU 0x11 -> 0x000000BE; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
- Partial store: SB 0x5A to 0x13, SH 0x1234 to 0x10, then LW 0x10 -> 0x5AAD1234.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid and rsp_rdata stable throughout, req_ready=0, a new req_valid is not accepted; release -> IDLE next cycle.
- Errors:
  - With DMEM_ERR_RESP_EN defined: LH 0x11 -> rsp_err=1, rsp_rdata=0.
  - With DMEM_ERR_RESP_EN defined: SW to 0x1002 -> rsp_err=1 and memory unchanged.
  - Without DMEM_ERR_RESP_EN: LH 0x11 returns the half at 0x10 with rsp_err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: load/store memory responder with wait states; DMEM_ERR_RESP_EN enables error responses
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic c_we, c_uns;
  logic [1:0] c_size;
  logic [XLEN-1:0] c_addr, c_wdata;
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic we, uns, err, go;
  logic [1:0] size, esize, lane;
  logic [XLEN-1:0] addr, wdata, word, ld, st_data;
  logic [AW-1:0] idx;
  logic [3:0] be;
  logic [7:0] b;
  logic [15:0] h;
  // In IDLE the live request is used so a zero-wait access can hit RAM on its acceptance edge
  assign we    = state == IDLE ? req_we : c_we;
  assign uns   = state == IDLE ? req_unsigned : c_uns;
  assign size  = state == IDLE ? req_size : c_size;
  assign addr  = state == IDLE ? req_addr : c_addr;
  assign wdata = state == IDLE ? req_wdata : c_wdata;
  assign esize = size == 2'b11 ? 2'b10 : size;
  assign lane  = esize == 2'b00 ? addr[1:0] : esize == 2'b01 ? {addr[1], 1'b0} : 2'b00;
  assign idx   = addr[AW+1:2];
  assign word  = mem[idx];
  assign b     = word[8*lane +: 8];
  assign h     = word[16*lane[1] +: 16];
  assign ld    = esize == 2'b00 ? {{(XLEN-8){b[7] & ~uns}}, b} :
                 esize == 2'b01 ? {{(XLEN-16){h[15] & ~uns}}, h} : word;
  assign be    = esize == 2'b00 ? 4'b0001 << lane : esize == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_data = esize == 2'b00 ? {(XLEN/8){wdata[7:0]}} : esize == 2'b01 ? {(XLEN/16){wdata[15:0]}} : wdata;
`ifdef DMEM_ERR_RESP_EN
  assign err = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) ||
               (addr >> (AW + 2)) != '0;
`else
  logic unused_hi;
  assign err = 1'b0;
  assign unused_hi = ^addr[XLEN-1:AW+2];
`endif
  assign go = (state == IDLE && req_valid && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  always_comb begin
    state_n = state;
    if (state == IDLE && req_valid) state_n = WAIT_CYCLES == 0 ? RESP : WAIT;
    if (state == WAIT && cnt == 4'd0) state_n = RESP;
    if (state == RESP && rsp_ready) state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        c_we    <= req_we;
        c_uns   <= req_unsigned;
        c_size  <= req_size;
        c_addr  <= req_addr;
        c_wdata <= req_wdata;
        cnt     <= 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (go) begin
        rsp_rdata <= (we || err) ? '0 : ld;
        rsp_err   <= err;
      end else if (state == RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && go && we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
endmodule
